// File: rtl/fpaddsub_align_fine.sv
// -----------------------------------------------------------------------------
// fpaddsub_align_fine
//
// Fine alignment stage of the FP add/sub datapath. This stage follows the
// coarse alignment shifter. It applies the remaining 0..3-bit right shift to
// the smaller mantissa and forms the {guard, round, sticky} bits. The result
// is registered behind a valid/ready handshake. A two-entry skid buffer lets
// the downstream stage stall without losing throughput.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   upstream word valid
//   in_ready   stage can accept (registered)
//   in_mmin    smaller mantissa after coarse shift (MW bits, hidden bit incl.)
//   in_shift   residual right shift, 0..3
//   in_sticky  OR of the bits discarded by the coarse shift
//   in_flush   mantissa shifts out entirely (overrides in_shift)
//   in_side    sideband, carried with the word untouched
//   out_valid  output word valid
//   out_ready  downstream accepts
//   out_mmin   aligned smaller mantissa
//   out_grs    {guard, round, sticky}
//   out_side   sideband of the same word
//
// Handshake: a word moves across an interface on a rising clk edge where
// valid and ready are both 1. A producer holds its payload stable while
// valid=1 and ready=0. in_* may change freely while in_ready=0.
// -----------------------------------------------------------------------------
module fpaddsub_align_fine #(
    parameter int MW     = 24,
    parameter int SIDE_W = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MW-1:0]     in_mmin,
    input  logic [1:0]        in_shift,
    input  logic              in_sticky,
    input  logic              in_flush,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MW-1:0]     out_mmin,
    output logic [2:0]        out_grs,
    output logic [SIDE_W-1:0] out_side
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, next_state;

    logic [MW-1:0]     aln_mmin;
    logic [2:0]        aln_grs;

    logic [MW-1:0]     main_mmin, skid_mmin;
    logic [2:0]        main_grs,  skid_grs;
    logic [SIDE_W-1:0] main_side, skid_side;

    logic accept, transfer;
    logic load_main, load_skid, main_from_skid;

    // Alignment datapath. Bits shifted out beyond the round position fold
    // into sticky. A flush sends the whole mantissa into sticky.
    always_comb begin
        aln_mmin = in_mmin;
        aln_grs  = {2'b00, in_sticky};
        if (in_flush) begin
            aln_mmin = '0;
            aln_grs  = {2'b00, (|in_mmin) | in_sticky};
        end else begin
            case (in_shift)
                2'd1: begin
                    aln_mmin = in_mmin >> 1;
                    aln_grs  = {in_mmin[0], 1'b0, in_sticky};
                end
                2'd2: begin
                    aln_mmin = in_mmin >> 2;
                    aln_grs  = {in_mmin[1], in_mmin[0], in_sticky};
                end
                2'd3: begin
                    aln_mmin = in_mmin >> 3;
                    aln_grs  = {in_mmin[2], in_mmin[1], in_mmin[0] | in_sticky};
                end
                default: begin
                    aln_mmin = in_mmin;
                    aln_grs  = {2'b00, in_sticky};
                end
            endcase
        end
    end

    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;

    // Next state and register load controls. The main register always holds
    // the oldest word. The skid register only fills when main is stalled.
    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    next_state = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (accept && transfer) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (transfer) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                if (transfer) begin
                    next_state     = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b0;
            main_mmin <= '0;
            main_grs  <= '0;
            main_side <= '0;
            skid_mmin <= '0;
            skid_grs  <= '0;
            skid_side <= '0;
        end else begin
            state    <= next_state;
            // Registered ready: it drops as the buffer fills, so the
            // skid entry absorbs the word accepted in that same cycle.
            in_ready <= (next_state != FULL);
            if (load_main) begin
                main_mmin <= aln_mmin;
                main_grs  <= aln_grs;
                main_side <= in_side;
            end else if (main_from_skid) begin
                main_mmin <= skid_mmin;
                main_grs  <= skid_grs;
                main_side <= skid_side;
            end
            if (load_skid) begin
                skid_mmin <= aln_mmin;
                skid_grs  <= aln_grs;
                skid_side <= in_side;
            end
        end
    end

    assign out_mmin = main_mmin;
    assign out_grs  = main_grs;
    assign out_side = main_side;

endmodule
